cell_sweep_driver: RTL and testbench
====================================

CELL_SWEEP_DRIVER -- requirements
Module: cell_sweep_driver

Interface
REQ-001 The module SHALL have parameter SETTLE, default 10, giving cycles in_vec is held before ZN is sampled (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a full 64-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate a running sweep; priority over start.
REQ-006 zn_in  input  1  ZN output of the OAI222 cell under test.
REQ-007 in_vec  output  6  cell stimulus, bit5..bit0 = A1,A2,B1,B2,C1,C2.
REQ-008 busy  output  1  high while in SETTLE or SAMPLE.
REQ-009 sample_valid  output  1  one-cycle pulse qualifying sample_vec/sample_zn/mismatch.
REQ-010 sample_vec  output  6  vector that was sampled.
REQ-011 sample_zn  output  1  captured zn_in.
REQ-012 mismatch  output  1  sample_zn differs from golden for sample_vec.
REQ-013 err_count  output  7  mismatches in current/last sweep (0..64).
REQ-014 done  output  1  one-cycle pulse at normal sweep completion.
REQ-015 pass  output  1  last completed sweep had err_count==0; held until next start.

Function
REQ-016 Golden SHALL be ZN = NOT((A1|A2)&(B1|B2)&(C1|C2)), combinational on in_vec; ZN=0 for exactly 27 of 64 vectors.
REQ-017 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-018 IDLE: start=1 and abort=0 -> SETTLE; in_vec<=0, settle counter<=0, err_count<=0, pass<=0.
REQ-019 SETTLE: counter increments each cycle; when counter==SETTLE-1 -> SAMPLE.
REQ-020 SAMPLE: lasts one cycle; at its ending edge zn_in captured into sample_zn, sample_vec<=in_vec, mismatch<=(zn_in!=golden), err_count incremented on mismatch, sample_valid=1 for the following cycle.
REQ-021 SAMPLE with in_vec<63 -> SETTLE, in_vec<=in_vec+1, counter<=0 on the same edge.
REQ-022 SAMPLE with in_vec==63 -> DONE, in_vec unchanged (no wrap to 0 during sweep), pass<=(final err_count==0).
REQ-023 DONE: done=1 for exactly one cycle (coincides with last sample_valid), busy=0, then -> IDLE; in_vec<=0.
REQ-024 Vectors SHALL be applied in ascending order 0..63; each held SETTLE+1 cycles; start-to-done latency = 64*(SETTLE+1)+1 cycles.
REQ-025 start while busy or in DONE SHALL be ignored (not queued).
REQ-026 abort=1 in SETTLE/SAMPLE SHALL force IDLE next edge: in_vec<=0, no sample_valid, no done, err_count and pass hold; abort in IDLE/DONE no effect beyond blocking start.
REQ-027 sample_valid, mismatch, done SHALL be 0 whenever not explicitly pulsed.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and all outputs to 0 (in_vec=0, busy=0, sample_valid=0, sample_vec=0, sample_zn=0, mismatch=0, err_count=0, done=0, pass=0), including mid-sweep.
REQ-029 First start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-030 Behavioural OAI222 on zn_in, SETTLE=10, start pulse -> 64 sample_valid pulses with sample_vec 0..63 in order, done 705 cycles after start, err_count=0, pass=1.
REQ-031 zn_in tied 0 -> err_count=37, pass=0; zn_in tied 1 -> err_count=27, pass=0.
REQ-032 Golden spot-checks with good model: sample_vec 000000 -> sample_zn=1, 010101 -> 0, 111111 -> 0, 110011 -> 1; mismatch=0 throughout.
REQ-033 abort asserted while in_vec=20 -> in_vec=0 and busy=0 next cycle, no done, err_count held; start in same cycle as abort in IDLE -> stays IDLE.
REQ-034 start pulsed while busy and in DONE cycle -> ignored, sweep count/timing unchanged; SETTLE=1 run -> done at cycle 129.
REQ-035 rst_n low at vector 40 -> all outputs 0 asynchronously; fresh start after release -> full correct sweep from vector 0.

Source files
------------

// File: rtl/cell_sweep_driver.sv
// Exhaustive 64-vector stimulus driver for an OAI222 cell: applies each vector,
// waits SETTLE cycles, samples ZN, compares against the ideal function and tallies errors.
module cell_sweep_driver #(
  parameter int SETTLE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       zn_in,
  output logic [5:0] in_vec,
  output logic       busy,
  output logic       sample_valid,
  output logic [5:0] sample_vec,
  output logic       sample_zn,
  output logic       mismatch,
  output logic [6:0] err_count,
  output logic       done,
  output logic       pass
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] vec_q, vec_d, svec_q, svec_d;
  logic [6:0] err_q, err_d;
  logic       busy_q, busy_d, sv_q, sv_d, szn_q, szn_d;
  logic       mis_q, mis_d, done_q, done_d, pass_q, pass_d;
  logic       golden, zn_bad;

  // Bits 5..0 = A1,A2,B1,B2,C1,C2.
  assign golden = ~((vec_q[5] | vec_q[4]) & (vec_q[3] | vec_q[2]) & (vec_q[1] | vec_q[0]));
  assign zn_bad = zn_in ^ golden;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    svec_d  = svec_q;
    szn_d   = szn_q;
    err_d   = err_q;
    pass_d  = pass_q;
    sv_d    = 1'b0;
    mis_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          vec_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          vec_d   = '0;
        end else begin
          sv_d   = 1'b1;
          svec_d = vec_q;
          szn_d  = zn_in;
          mis_d  = zn_bad;
          err_d  = err_q + {6'd0, zn_bad};
          if (vec_q == 6'd63) begin
            // Final vector: no wrap, report on the same edge as the last sample.
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == 7'd0);
          end else begin
            state_d = S_SETTLE;
            vec_d   = vec_q + 6'd1;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      svec_q  <= '0;
      szn_q   <= 1'b0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
      mis_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      svec_q  <= svec_d;
      szn_q   <= szn_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      sv_q    <= sv_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign in_vec       = vec_q;
  assign busy         = busy_q;
  assign sample_valid = sv_q;
  assign sample_vec   = svec_q;
  assign sample_zn    = szn_q;
  assign mismatch     = mis_q;
  assign err_count    = err_q;
  assign done         = done_q;
  assign pass         = pass_q;
endmodule

// File: tb/tb_cell_sweep_driver.sv
// Directed bench for cell_sweep_driver: one instance with SETTLE=10, one with SETTLE=1,
// each fed by a behavioural OAI222 (optionally stuck-at) on zn_in.
module tb_cell_sweep_driver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start10 = 0, abort10 = 0, zn10;
  logic [5:0] iv10, sv10;
  logic       busy10, val10, szn10, mis10, done10, pass10;
  logic [6:0] err10;

  logic       start1 = 0, abort1 = 0, zn1;
  logic [5:0] iv1, sv1;
  logic       busy1, val1, szn1, mis1, done1, pass1;
  logic [6:0] err1;

  int zmode = 0;  // 0 good cell, 1 stuck-at-0, 2 stuck-at-1
  bit cur = 0;    // 0 selects SETTLE=10 instance, 1 selects SETTLE=1 instance
  int total = 0, bad = 0;

  function automatic logic oai222(input logic [5:0] v);
    return ~((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  assign zn10 = (zmode == 1) ? 1'b0 : (zmode == 2) ? 1'b1 : oai222(iv10);
  assign zn1  = oai222(iv1);

  cell_sweep_driver #(.SETTLE(10)) u10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .abort(abort10), .zn_in(zn10),
    .in_vec(iv10), .busy(busy10), .sample_valid(val10), .sample_vec(sv10),
    .sample_zn(szn10), .mismatch(mis10), .err_count(err10), .done(done10), .pass(pass10));

  cell_sweep_driver #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .zn_in(zn1),
    .in_vec(iv1), .busy(busy1), .sample_valid(val1), .sample_vec(sv1),
    .sample_zn(szn1), .mismatch(mis1), .err_count(err1), .done(done1), .pass(pass1));

  logic       m_val, m_done, m_mis, m_szn;
  logic [5:0] m_svec;
  assign m_val  = cur ? val1  : val10;
  assign m_done = cur ? done1 : done10;
  assign m_mis  = cur ? mis1  : mis10;
  assign m_szn  = cur ? szn1  : szn10;
  assign m_svec = cur ? sv1   : sv10;

  task automatic drive(input logic v);
    if (cur) start1 = v; else start10 = v;
  endtask

  // Runs one sweep on the selected instance, counting from the cycle start is high (cycle 0).
  task automatic sweep(input bit poke, output int nv, output int obad, output int dcyc,
                       output int mseen, output logic [63:0] zc, output int fvc);
    int cyc = 0;
    nv = 0; obad = 0; dcyc = -1; mseen = 0; zc = '0; fvc = -1;
    @(negedge clk); drive(1'b1);
    while (cyc < 3000 && dcyc < 0) begin
      @(posedge clk); cyc++; #1;
      drive(poke && (cyc == 50 || m_done));
      if (m_val) begin
        if (fvc < 0) fvc = cyc;
        if (m_svec != nv[5:0]) obad++;
        zc[m_svec] = m_szn;
        if (m_mis) mseen++;
        nv++;
      end
      if (m_done) dcyc = cyc;
    end
    @(posedge clk); #1; drive(1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({iv10, busy10, val10, sv10, szn10, mis10, err10, done10, pass10} !== 26'd0) begin
      bad++; $display("FAIL reset_u10: got %h exp 0", {iv10, busy10, val10, sv10, szn10, mis10, err10, done10, pass10});
    end
    total++;
    if ({iv1, busy1, val1, sv1, szn1, mis1, err1, done1, pass1} !== 26'd0) begin
      bad++; $display("FAIL reset_u1: got %h exp 0", {iv1, busy1, val1, sv1, szn1, mis1, err1, done1, pass1});
    end
  endtask

  task automatic test_first_start;
    @(negedge clk); rst_n = 1'b1; start10 = 1'b1;
    @(posedge clk); #1; start10 = 1'b0;
    total++;
    if (busy10 !== 1'b1 || iv10 !== 6'd0) begin
      bad++; $display("FAIL first_start: busy=%b in_vec=%0d exp busy=1 in_vec=0", busy10, iv10);
    end
    abort10 = 1'b1;
    @(posedge clk); #1; abort10 = 1'b0;
    total++;
    if (busy10 !== 1'b0) begin bad++; $display("FAIL abort_after_start: busy=%b exp 0", busy10); end
  endtask

  task automatic test_good_sweep;
    int nv, obad, dcyc, mseen, fvc, gbad;
    logic [63:0] zc;
    cur = 0; zmode = 0;
    sweep(1'b0, nv, obad, dcyc, mseen, zc, fvc);
    total++; if (nv != 64) begin bad++; $display("FAIL good_valid_count: got %0d exp 64", nv); end
    total++; if (obad != 0) begin bad++; $display("FAIL good_order: got %0d out-of-order exp 0", obad); end
    total++; if (dcyc != 705) begin bad++; $display("FAIL good_done_latency: got %0d exp 705", dcyc); end
    total++; if (fvc != 12) begin bad++; $display("FAIL good_first_valid: got %0d exp 12", fvc); end
    total++; if (err10 !== 7'd0) begin bad++; $display("FAIL good_err: got %0d exp 0", err10); end
    total++; if (pass10 !== 1'b1) begin bad++; $display("FAIL good_pass: got %b exp 1", pass10); end
    total++; if (mseen != 0) begin bad++; $display("FAIL good_mismatch: got %0d pulses exp 0", mseen); end
    total++;
    if ({zc[0], zc[21], zc[63], zc[51]} !== 4'b1001) begin
      bad++; $display("FAIL golden_spot: got %b exp 1001", {zc[0], zc[21], zc[63], zc[51]});
    end
    gbad = 0;
    for (int i = 0; i < 64; i++) if (zc[i] !== oai222(6'(i))) gbad++;
    total++; if (gbad != 0) begin bad++; $display("FAIL good_capture: got %0d wrong exp 0", gbad); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (pass10 !== 1'b1 || done10 !== 1'b0) begin
      bad++; $display("FAIL pass_hold: pass=%b done=%b exp pass=1 done=0", pass10, done10);
    end
  endtask

  task automatic test_stuck;
    int nv, obad, dcyc, mseen, fvc;
    logic [63:0] zc;
    cur = 0; zmode = 1;
    sweep(1'b0, nv, obad, dcyc, mseen, zc, fvc);
    total++; if (err10 !== 7'd37) begin bad++; $display("FAIL stuck0_err: got %0d exp 37", err10); end
    total++; if (mseen != 37) begin bad++; $display("FAIL stuck0_mismatch: got %0d exp 37", mseen); end
    total++; if (pass10 !== 1'b0) begin bad++; $display("FAIL stuck0_pass: got %b exp 0", pass10); end
    total++; if (dcyc != 705) begin bad++; $display("FAIL stuck0_latency: got %0d exp 705", dcyc); end
    zmode = 2;
    sweep(1'b0, nv, obad, dcyc, mseen, zc, fvc);
    total++; if (err10 !== 7'd27) begin bad++; $display("FAIL stuck1_err: got %0d exp 27", err10); end
    total++; if (pass10 !== 1'b0) begin bad++; $display("FAIL stuck1_pass: got %b exp 0", pass10); end
    zmode = 0;
  endtask

  task automatic test_abort;
    int cyc;
    bit seen_done;
    cur = 0; zmode = 1;
    @(negedge clk); start10 = 1'b1;
    @(posedge clk); #1; start10 = 1'b0;
    cyc = 0;
    while (iv10 != 6'd20 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    total++; if (iv10 !== 6'd20) begin bad++; $display("FAIL abort_reach20: got %0d exp 20", iv10); end
    abort10 = 1'b1;
    @(posedge clk); #1; abort10 = 1'b0;
    total++;
    if (iv10 !== 6'd0 || busy10 !== 1'b0 || val10 !== 1'b0) begin
      bad++; $display("FAIL abort_idle: in_vec=%0d busy=%b valid=%b exp 0 0 0", iv10, busy10, val10);
    end
    total++; if (err10 !== 7'd20) begin bad++; $display("FAIL abort_err_hold: got %0d exp 20", err10); end
    seen_done = 0;
    repeat (30) begin @(posedge clk); #1; if (done10 || busy10) seen_done = 1; end
    total++; if (seen_done) begin bad++; $display("FAIL abort_no_done: got activity exp none"); end
    start10 = 1'b1; abort10 = 1'b1;
    @(posedge clk); #1; start10 = 1'b0; abort10 = 1'b0;
    total++;
    if (busy10 !== 1'b0 || err10 !== 7'd20) begin
      bad++; $display("FAIL start_abort_idle: busy=%b err=%0d exp busy=0 err=20", busy10, err10);
    end
    zmode = 0;
  endtask

  task automatic test_back_to_back;
    int nv, obad, dcyc, mseen, fvc;
    logic [63:0] zc;
    cur = 1;
    sweep(1'b1, nv, obad, dcyc, mseen, zc, fvc);
    total++; if (nv != 64 || obad != 0) begin
      bad++; $display("FAIL s1_valid: got count=%0d order_bad=%0d exp 64 0", nv, obad);
    end
    total++; if (dcyc != 129) begin bad++; $display("FAIL s1_done_latency: got %0d exp 129", dcyc); end
    total++; if (busy1 !== 1'b0 || iv1 !== 6'd0) begin
      bad++; $display("FAIL s1_done_start_ignored: busy=%b in_vec=%0d exp 0 0", busy1, iv1);
    end
    total++; if (err1 !== 7'd0 || pass1 !== 1'b1) begin
      bad++; $display("FAIL s1_result: err=%0d pass=%b exp 0 1", err1, pass1);
    end
    cur = 0;
  endtask

  task automatic test_reset_mid;
    int cyc, nv, obad, dcyc, mseen, fvc;
    logic [63:0] zc;
    cur = 0; zmode = 0;
    @(negedge clk); start10 = 1'b1;
    @(posedge clk); #1; start10 = 1'b0;
    cyc = 0;
    while (iv10 != 6'd40 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({iv10, busy10, val10, sv10, szn10, mis10, err10, done10, pass10} !== 26'd0) begin
      bad++; $display("FAIL reset_mid: got %h exp 0", {iv10, busy10, val10, sv10, szn10, mis10, err10, done10, pass10});
    end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    sweep(1'b0, nv, obad, dcyc, mseen, zc, fvc);
    total++; if (nv != 64 || obad != 0 || dcyc != 705) begin
      bad++; $display("FAIL post_reset_sweep: count=%0d order_bad=%0d done=%0d exp 64 0 705", nv, obad, dcyc);
    end
    total++; if (err10 !== 7'd0 || pass10 !== 1'b1) begin
      bad++; $display("FAIL post_reset_result: err=%0d pass=%b exp 0 1", err10, pass10);
    end
  endtask

  initial begin
    test_reset();
    test_first_start();
    test_good_sweep();
    test_stuck();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
